// File: rtl/i2c_target_regfile.sv
// I2C target with an NREG x 8 register file and an auto-incrementing pointer.
// Define I2C_TARGET_GENCALL_EN to also ACK the general-call write address (0x00).
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         NREG     = 16,
    parameter int         FILT     = 3,
    localparam int        AW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          bus_wr_stb,
    output logic [AW-1:0] bus_wr_addr,
    output logic [7:0]    bus_wr_data,
    output logic          busy,
    output logic [3:0]    dbg_state_o
);

    localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // ---------------- input conditioning (bit 1 = SCL, bit 0 = SDA) ----------------
    logic [1:0]    pad;
    logic [1:0]    sync0_q, sync1_q, filt_q, prev_q;
    logic [CW-1:0] cnt_q [2];

    assign pad = {scl_i, sda_i};

    // Idle bus is high on both lines, so the whole chain resets to 1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync0_q <= pad;
            sync1_q <= sync0_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync1_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILT - 1)) begin
                    filt_q[i] <= sync1_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;

    assign sda_f     = filt_q[0];
    assign scl_rise  = filt_q[1] & ~prev_q[1];
    assign scl_fall  = ~filt_q[1] & prev_q[1];
    assign start_det = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
    assign stop_det  = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];

    // ---------------- protocol state ----------------
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic          mack_q, mack_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NREG];
    logic          addr_match;

    assign ptr_inc = ptr_q + 1'b1;

`ifdef I2C_TARGET_GENCALL_EN
    assign addr_match = (shift_q[7:1] == DEV_ADDR) || (shift_q == 8'h00);
`else
    assign addr_match = (shift_q[7:1] == DEV_ADDR);
`endif

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (stop_det) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (bitcnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sda_f};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                RDATA: begin
                    if (bitcnt_q < 4'd8) bitcnt_d = bitcnt_q + 4'd1;
                end
                RDATA_ACK: mack_d = ~sda_f;
                default: ;
            endcase
        end else if (scl_fall) begin
            // All SDA updates happen here, i.e. only while SCL is low.
            case (state_q)
                ADDR: begin
                    if (bitcnt_q == 4'd8) begin
                        bitcnt_d = '0;
                        if (addr_match) begin
                            state_d  = ADDR_ACK;
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (rw_q) begin
                        state_d  = RDATA;
                        shift_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end else begin
                        state_d  = PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                PTR: begin
                    if (bitcnt_q == 4'd8) begin
                        ptr_d    = shift_q[AW-1:0];
                        bitcnt_d = '0;
                        sda_oe_d = 1'b1;
                        state_d  = PTR_ACK;
                    end
                end
                WDATA: begin
                    if (bitcnt_q == 4'd8) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = shift_q;
                        ptr_d     = ptr_inc;
                        bitcnt_d  = '0;
                        sda_oe_d  = 1'b1;
                        state_d   = WDATA_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    state_d  = WDATA;
                    sda_oe_d = 1'b0;
                end
                RDATA: begin
                    if (bitcnt_q == 4'd8) begin
                        bitcnt_d = '0;
                        sda_oe_d = 1'b0;
                        state_d  = RDATA_ACK;
                    end else begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    if (mack_q) begin
                        ptr_d    = ptr_inc;
                        shift_d  = regs_q[ptr_inc];
                        sda_oe_d = ~regs_q[ptr_inc][7];
                        state_d  = RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // ---------------- register file ----------------
    // The bus commit lands in the same cycle bus_wr_stb is high; it wins an address clash.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            host_rdata <= '0;
        end else begin
            if (host_we && !(wr_stb_q && (wr_addr_q == host_addr)))
                regs_q[host_addr] <= host_wdata;
            if (wr_stb_q)
                regs_q[wr_addr_q] <= wr_data_q;
            host_rdata <= regs_q[host_addr];
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign bus_wr_stb  = wr_stb_q;
    assign bus_wr_addr = wr_addr_q;
    assign bus_wr_data = wr_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: bit-banged I2C master, host-port driver,
// transaction-level register model and a write-strobe scoreboard.
module tb_i2c_target_regfile;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       bus_wr_stb;
  logic [3:0] bus_wr_addr;
  logic [7:0] bus_wr_data;
  logic       busy;
  logic [3:0] dbg_state;

  assign sda_line = sda_m & ~sda_oe;  // open-drain wired-AND

  i2c_target_regfile dut (
    .clk        (clk),
    .resetn     (resetn),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .bus_wr_stb (bus_wr_stb),
    .bus_wr_addr(bus_wr_addr),
    .bus_wr_data(bus_wr_data),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- model and scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  model_regs [16];
  int          model_ptr = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        sda_oe_seen = 1'b0;
  logic        glitch = 1'b0;

  always @(negedge clk) begin
    if (bus_wr_stb) obs_q.push_back({4'h0, bus_wr_addr, bus_wr_data});
    if (sda_oe) sda_oe_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_bus_write(input logic [7:0] d);
    model_regs[model_ptr] = d;
    exp_q.push_back(16'(model_ptr * 256 + int'(d)));
    model_ptr = (model_ptr + 1) % 16;
  endtask

  task automatic check_strobes();
    logic [15:0] e;
    tick(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_stb_missing: got none expected 0x%0h", e);
      end else begin
        check("wr_stb", obs_q.pop_front(), e);
      end
    end
    while (obs_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL wr_stb_extra: got 0x%0h expected none", obs_q.pop_front());
    end
  endtask

  // ---------------- host driver ----------------
  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    tick(1);
    host_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    tick(1);
    d = host_rdata;
  endtask

  task automatic check_all_regs(input string name);
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      host_read(4'(i), d);
      check(name, d, model_regs[i]);
    end
  endtask

  // ---------------- I2C master driver ----------------
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    if (glitch) begin
      tick(Q / 2); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q / 2 - 1);
      scl_m = 1'b1; tick(Q); sda_m = ~b; tick(1); sda_m = b; tick(Q - 1);
    end else begin
      tick(Q); scl_m = 1'b1; tick(2 * Q);
    end
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [7:0] abyte;
    logic       exp_ack;
  } avec_t;

  avec_t vecs[8];

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] p;
    int         n;
    int         kind;

    vecs[0] = '{8'h72, 1'b1};
    vecs[1] = '{8'h73, 1'b1};
    vecs[2] = '{8'hA0, 1'b0};
    vecs[3] = '{8'h70, 1'b0};
`ifdef I2C_TARGET_GENCALL_EN
    vecs[4] = '{8'h00, 1'b1};
`else
    vecs[4] = '{8'h00, 1'b0};
`endif
    vecs[5] = '{8'h01, 1'b0};
    vecs[6] = '{8'hF2, 1'b0};
    vecs[7] = '{8'h78, 1'b0};
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

    // reset state
    tick(4);
    resetn = 1'b1;
    tick(1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_stb", bus_wr_stb, 0);
    check("rst_wr_addr", bus_wr_addr, 0);
    check("rst_wr_data", bus_wr_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_state_idle", dbg_state, 0);

    // reset in the middle of an address ACK
    host_write(4'd0, 8'hAA);
    host_write(4'd7, 8'h55);
    host_write(4'd15, 8'hC3);
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(p_bit(8'h72, i));
    sda_m = 1'b1;
    check("midack_sda_oe", sda_oe, 1);
    check("midack_busy", busy, 1);
    resetn = 1'b0;
    tick(1);
    check("midack_rst_sda_oe", sda_oe, 0);
    check("midack_rst_busy", busy, 0);
    tick(1);
    resetn = 1'b1;
    scl_m = 1'b1;
    tick(2 * Q);
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    obs_q.delete();
    check_all_regs("midack_regs_zero");

    // write with filter glitches on the first data byte
    i2c_start();
    send_byte(8'h72, ack); check("wr_ack_addr", ack, 1);
    send_byte(8'h03, ack); check("wr_ack_ptr", ack, 1);
    model_ptr = 3;
    glitch = 1'b1;
    send_byte(8'hA5, ack); check("wr_ack_d0", ack, 1);
    glitch = 1'b0;
    model_bus_write(8'hA5);
    send_byte(8'h5A, ack); check("wr_ack_d1", ack, 1);
    model_bus_write(8'h5A);
    i2c_stop();
    check_strobes();
    host_read(4'd4, d);
    check("wr_reg4", d, 8'h5A);
    host_read(4'd3, d);
    check("wr_reg3", d, 8'hA5);

    // read with repeated START
    host_write(4'd2, 8'h12);
    host_write(4'd3, 8'h34);
    i2c_start();
    send_byte(8'h72, ack); check("rd_ack_addr", ack, 1);
    send_byte(8'h02, ack); check("rd_ack_ptr", ack, 1);
    i2c_start();
    send_byte(8'h73, ack); check("rd_ack_raddr", ack, 1);
    recv_byte(d, 1'b1); check("rd_byte0", d, 8'h12);
    recv_byte(d, 1'b0); check("rd_byte1", d, 8'h34);
    model_ptr = 3;
    check("rd_sda_released", sda_oe, 0);
    check("rd_busy_before_stop", busy, 1);
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);
    check_strobes();

    // wrong address
    sda_oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack); check("wa_nack_addr", ack, 0);
    send_byte(8'h01, ack); check("wa_nack_b1", ack, 0);
    send_byte(8'hFF, ack); check("wa_nack_b2", ack, 0);
    check("wa_busy", busy, 0);
    i2c_stop();
    check("wa_sda_oe_seen", sda_oe_seen, 0);
    check_strobes();
    check_all_regs("wa_regs");

    // pointer wrap with host-write collisions in the commit cycles
    fork
      begin
        i2c_start();
        send_byte(8'h72, ack); check("wrap_ack_addr", ack, 1);
        send_byte(8'h0F, ack); check("wrap_ack_ptr", ack, 1);
        model_ptr = 15;
        send_byte(8'h11, ack); check("wrap_ack_d0", ack, 1);
        send_byte(8'h22, ack); check("wrap_ack_d1", ack, 1);
        send_byte(8'h33, ack); check("wrap_ack_d2", ack, 1);
        i2c_stop();
      end
      begin
        int   guard;
        logic hit0, hit1;
        guard = 0;
        hit0 = 1'b0;
        hit1 = 1'b0;
        while (!(hit0 && hit1) && guard < 5000) begin
          @(negedge clk);
          guard++;
          host_we = 1'b0;
          if (bus_wr_stb && bus_wr_addr == 4'd0 && !hit0) begin
            host_we = 1'b1; host_addr = 4'd0; host_wdata = 8'h99; hit0 = 1'b1;
          end else if (bus_wr_stb && bus_wr_addr == 4'd1 && !hit1) begin
            host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h77; hit1 = 1'b1;
          end
        end
        @(negedge clk);
        host_we = 1'b0;
        check("collide_hits", {hit0, hit1}, 2'b11);
      end
    join
    model_bus_write(8'h11);
    model_bus_write(8'h22);
    model_bus_write(8'h33);
    model_regs[5] = 8'h77;
    check_strobes();
    host_read(4'd15, d); check("wrap_reg15", d, 8'h11);
    host_read(4'd0, d);  check("collide_same_reg0", d, 8'h22);
    host_read(4'd1, d);  check("wrap_reg1", d, 8'h33);
    host_read(4'd5, d);  check("collide_diff_reg5", d, 8'h77);

    // abort mid-byte
    i2c_start();
    send_byte(8'h72, ack); check("ab_ack_addr", ack, 1);
    send_byte(8'h08, ack); check("ab_ack_ptr", ack, 1);
    model_ptr = 8;
    for (int i = 7; i >= 4; i--) send_bit(p_bit(8'hC3, i));
    i2c_stop();
    tick(2);
    check("ab_state_idle", dbg_state, 0);
    check("ab_busy", busy, 0);
    check_strobes();
    i2c_start();
    send_byte(8'h73, ack); check("ab_ack_raddr", ack, 1);
    recv_byte(d, 1'b0); check("ab_read_ptr_kept", d, model_regs[8]);
    i2c_stop();
    i2c_start();
    send_byte(8'h72, ack); check("ab2_ack_addr", ack, 1);
    send_byte(8'h08, ack); check("ab2_ack_ptr", ack, 1);
    model_ptr = 8;
    send_byte(8'hC3, ack); check("ab2_ack_d", ack, 1);
    model_bus_write(8'hC3);
    i2c_stop();
    check_strobes();
    host_read(4'd8, d); check("ab2_reg8", d, 8'hC3);

    // address-byte table
    for (int v = 0; v < 8; v++) begin
      sda_oe_seen = 1'b0;
      i2c_start();
      send_byte(vecs[v].abyte, ack);
      check($sformatf("tbl_ack_%02h", vecs[v].abyte), ack, vecs[v].exp_ack);
      check($sformatf("tbl_busy_%02h", vecs[v].abyte), busy, vecs[v].exp_ack);
      if (ack && vecs[v].abyte[0]) begin
        recv_byte(d, 1'b0);
        check($sformatf("tbl_rd_%02h", vecs[v].abyte), d, model_regs[model_ptr]);
      end
      i2c_stop();
      check($sformatf("tbl_oe_seen_%02h", vecs[v].abyte), sda_oe_seen, vecs[v].exp_ack);
      check($sformatf("tbl_busy_end_%02h", vecs[v].abyte), busy, 0);
      check_strobes();
    end

    // randomized transactions against the model
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        p = 8'($urandom_range(0, 255));
        n = $urandom_range(0, 3);
        i2c_start();
        send_byte(8'h72, ack); check("rnd_w_ack_addr", ack, 1);
        send_byte(p, ack); check("rnd_w_ack_ptr", ack, 1);
        model_ptr = int'(p) % 16;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d, ack); check("rnd_w_ack_d", ack, 1);
          model_bus_write(d);
        end
        i2c_stop();
      end else if (kind == 1) begin
        n = $urandom_range(1, 3);
        i2c_start();
        if ($urandom_range(0, 1) == 1) begin
          p = 8'($urandom_range(0, 255));
          send_byte(8'h72, ack); check("rnd_r_ack_addr", ack, 1);
          send_byte(p, ack); check("rnd_r_ack_ptr", ack, 1);
          model_ptr = int'(p) % 16;
          i2c_start();
        end
        send_byte(8'h73, ack); check("rnd_r_ack_raddr", ack, 1);
        for (int k = 0; k < n; k++) begin
          recv_byte(d, k != n - 1);
          check("rnd_r_data", d, model_regs[model_ptr]);
          if (k != n - 1) model_ptr = (model_ptr + 1) % 16;
        end
        i2c_stop();
      end else begin
        host_write(4'($urandom_range(0, 15)), 8'($urandom));
      end
      check_strobes();
    end
    check_all_regs("final_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic p_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
